mem_stream_reader: RTL

// - Linear-burst read master for one direct wide port of the memory island (mem_wide_req_i/rsp_o side).
// - Issues one word request per cycle from base_addr_i for len_i beats; streams rdata out on valid/ready.
// - Memory rsp has no backpressure, so issue is credit-limited by free response-FIFO slots.
// - Feeds accelerator datapaths directly, bypassing the AXI adapters.

---
 rtl/mem_stream_reader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: linear-burst read master for one wide memory port.
// It issues one word request per cycle from base_addr_i for len_i beats.
// Read data is returned on a valid/ready stream through a registered response FIFO.
// The memory response path has no backpressure, so a new request is only issued
// while (outstanding + fifo_count) < FifoDepth.
// Optional build macro: MEM_STREAM_RD_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of ISSUE cycles stalled on grant or on credits.
module mem_stream_reader #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef MEM_STREAM_RD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [AddrWidth-1:0] Stride  = AddrWidth'(DataWidth / 8);
  localparam logic [CntWidth:0]    DepthC  = (CntWidth + 1)'(FifoDepth);
  localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(FifoDepth - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [LenWidth-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [CntWidth-1:0]   outst_q, outst_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [DataWidth-1:0]  fifo_q [FifoDepth];
  logic [DataWidth-1:0]  fifo_d [FifoDepth];

  logic credit_ok_s;
  logic grant_s;
  logic push_s;
  logic pop_s;
  logic start_acc_s;
  logic last_grant_s;

  // Handshake and credit decode shared by the FSM and the datapath.
  always_comb begin
    credit_ok_s  = ({1'b0, outst_q} + {1'b0, count_q}) < DepthC;
    grant_s      = mem_req_o & mem_gnt_i;
    // A response with nothing outstanding is a protocol error and is dropped.
    // This also discards late responses that arrive after a reset.
    push_s       = mem_rvalid_i & (outst_q != {CntWidth{1'b0}});
    pop_s        = valid_o & ready_i;
    start_acc_s  = (state_q == S_IDLE) & start_i;
    last_grant_s = grant_s & ((issue_cnt_q + LenWidth'(1)) == len_q);
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (len_i == {LenWidth{1'b0}}) ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (last_grant_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Finish once nothing is in flight and the last beat leaves the FIFO this cycle.
        if ((outst_q == {CntWidth{1'b0}}) && !mem_rvalid_i && (count_d == {CntWidth{1'b0}})) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request address, beat counter, outstanding counter and FIFO bookkeeping.
  always_comb begin
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    len_d       = len_q;
    if (start_acc_s) begin
      addr_d      = base_addr_i;
      issue_cnt_d = {LenWidth{1'b0}};
      len_d       = len_i;
    end else if (grant_s) begin
      addr_d      = addr_q + Stride;
      issue_cnt_d = issue_cnt_q + LenWidth'(1);
    end else begin
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
    end

    case ({grant_s, push_s})
      2'b10:   outst_d = outst_q + CntWidth'(1);
      2'b01:   outst_d = outst_q - CntWidth'(1);
      default: outst_d = outst_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase

    fifo_d = fifo_q;
    if (push_s) begin
      fifo_d[wptr_q] = mem_rdata_i;
      wptr_d         = (wptr_q == PtrLast) ? {PtrWidth{1'b0}} : wptr_q + PtrWidth'(1);
    end else begin
      wptr_d         = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == PtrLast) ? {PtrWidth{1'b0}} : rptr_q + PtrWidth'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= {AddrWidth{1'b0}};
      issue_cnt_q <= {LenWidth{1'b0}};
      len_q       <= {LenWidth{1'b0}};
      outst_q     <= {CntWidth{1'b0}};
      count_q     <= {CntWidth{1'b0}};
      wptr_q      <= {PtrWidth{1'b0}};
      rptr_q      <= {PtrWidth{1'b0}};
      fifo_q      <= '{default: {DataWidth{1'b0}}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      len_q       <= len_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_q      <= fifo_d;
    end
  end

  // Output decode from registered state only.
  // The request depends only on registered state, so it cannot be retracted while ungranted.
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    mem_req_o  = (state_q == S_ISSUE) & credit_ok_s;
    mem_addr_o = addr_q;
    mem_we_o   = 1'b0;
    valid_o    = (count_q != {CntWidth{1'b0}});
    data_o     = fifo_q[rptr_q];
  end

`ifdef MEM_STREAM_RD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: ungranted requests plus credit-starved ISSUE cycles, saturating.
  always_comb begin
    if (start_acc_s) begin
      stall_cnt_d = 32'd0;
    end else if ((state_q == S_ISSUE) && !grant_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
